// File: rtl/sd_spi_pkg.sv
// Shared constants and state types for the SPI-mode SD card responder.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_CRC_ERR   = 8'h08;
  localparam logic [7:0] R1_PARAM_ERR = 8'h40;

  localparam logic [7:0] START_TOKEN   = 8'hFE;
  localparam logic [7:0] DATA_ACCEPTED = 8'h05;
  localparam logic [7:0] CRC_CMD0      = 8'h95;
  localparam logic [7:0] CRC_CMD8      = 8'h87;

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD, ST_NCR, ST_RESP,
    ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
    ST_WR_WAIT, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_BUSY
  } state_e;

  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// Oversampled SPI mode-0 byte shifter: synchronisers, edge detect, rx framing, tx on falling edges.
// A loaded tx byte starts on the first falling sclk edge after the load; cs_n high resets framing.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       miso_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       cs_active_o
);

  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sh_q;
  logic       rx_valid_q;
  logic [7:0] tx_buf_q;
  logic [7:0] tx_sh_q;
  logic       tx_pend_q;
  logic       miso_q;
  logic       rise;
  logic       fall;
  logic       cs_hi;

  assign rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_hi = cs_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b11;
      cs_sync_q   <= 2'b11;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      rx_sh_q    <= 8'hFF;
      rx_valid_q <= 1'b0;
      tx_buf_q   <= 8'hFF;
      tx_sh_q    <= 8'hFF;
      tx_pend_q  <= 1'b0;
      miso_q     <= 1'b1;
    end else if (cs_hi) begin
      bit_cnt_q  <= 3'd0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= 8'hFF;
      tx_pend_q  <= 1'b0;
      miso_q     <= 1'b1;
    end else begin
      rx_valid_q <= rise && (bit_cnt_q == 3'd7);
      if (rise) begin
        rx_sh_q   <= {rx_sh_q[6:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (fall) begin
        if (tx_pend_q) begin
          miso_q    <= tx_buf_q[7];
          tx_sh_q   <= {tx_buf_q[6:0], 1'b1};
          tx_pend_q <= 1'b0;
        end else begin
          miso_q  <= tx_sh_q[7];
          tx_sh_q <= {tx_sh_q[6:0], 1'b1};
        end
      end
      // A load in the same clk as a falling edge is kept for the next byte.
      if (tx_load_i) begin
        tx_buf_q  <= tx_byte_i;
        tx_pend_q <= 1'b1;
      end
    end
  end

  assign miso_o      = miso_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_byte_o   = rx_sh_q;
  assign cs_active_o = ~cs_hi;

endmodule

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: init sequence, CMD17/CMD24 single blocks against internal memory.
// Acts once per received byte; the byte for the next slot is queued at each byte boundary.
module sd_spi_card_model
  import sd_spi_pkg::*;
#(
  parameter int MEM_BYTES  = 64,
  parameter int BLOCK_LEN  = 16,
  parameter int INIT_POLLS = 2,
  parameter int NCR        = 1,
  parameter int BUSY_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       cmd_strobe,
  output logic [5:0] cmd_index,
  output logic       in_idle
);

  localparam int          AW     = $clog2(MEM_BYTES);
  localparam logic [7:0]  BL_M1  = 8'(BLOCK_LEN - 1);
  localparam logic [7:0]  NCR_L  = 8'(NCR);
  localparam logic [7:0]  BUSY_L = 8'(BUSY_BYTES);
  localparam logic [7:0]  POLL_L = 8'(INIT_POLLS);
  localparam logic [32:0] MEM_L  = 33'(MEM_BYTES);
  localparam logic [32:0] BLK_L  = 33'(BLOCK_LEN);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      polls_q, polls_d;
  logic            app_q, app_d;
  logic            idle_q, idle_d;
  logic            strobe_q, strobe_d;
  logic [5:0]      index_q, index_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     arg_q, arg_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [4:0][7:0] resp_q, resp_d;
  logic [2:0]      len_q, len_d;

  logic [7:0]      mem_q [MEM_BYTES];
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic            tx_load;
  logic [7:0]      tx_byte;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            cs_active;
  logic [7:0]      r1_idle;
  logic            range_bad;

  spi_byte_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk),
    .mosi_i     (mosi),
    .cs_n_i     (cs_n),
    .tx_load_i  (tx_load),
    .tx_byte_i  (tx_byte),
    .miso_o     (miso),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .cs_active_o(cs_active)
  );

  assign r1_idle   = {7'b0, idle_q};
  assign range_bad = ({1'b0, arg_q} + BLK_L) > MEM_L;
  assign mem_addr  = addr_q + AW'(cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      op_q     <= OP_NONE;
      cnt_q    <= 8'd0;
      polls_q  <= 8'd0;
      app_q    <= 1'b0;
      idle_q   <= 1'b1;
      strobe_q <= 1'b0;
      index_q  <= 6'd0;
      idx_q    <= 6'd0;
      arg_q    <= 32'd0;
      addr_q   <= '0;
      resp_q   <= '1;
      len_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      polls_q  <= polls_d;
      app_q    <= app_d;
      idle_q   <= idle_d;
      strobe_q <= strobe_d;
      index_q  <= index_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      addr_q   <= addr_d;
      resp_q   <= resp_d;
      len_q    <= len_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'(i);
    end else if (mem_we) begin
      mem_q[mem_addr] <= rx_byte;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    polls_d  = polls_q;
    app_d    = app_q;
    idle_d   = idle_q;
    strobe_d = 1'b0;
    index_d  = index_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    addr_d   = addr_q;
    resp_d   = resp_q;
    len_d    = len_q;
    tx_load  = 1'b0;
    tx_byte  = 8'hFF;
    mem_we   = 1'b0;

    if (!cs_active) begin
      state_d = ST_HUNT;
      cnt_d   = 8'd0;
    end else if (rx_valid) begin
      tx_load = 1'b1;
      unique case (state_q)
        ST_HUNT: begin
          if (rx_byte[7:6] == 2'b01) begin
            idx_d   = rx_byte[5:0];
            cnt_d   = 8'd1;
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (cnt_q != 8'd5) begin
            arg_d = {arg_q[23:0], rx_byte};
            cnt_d = cnt_q + 8'd1;
          end else begin
            // Last byte is the CRC; decode and apply the command now.
            strobe_d = 1'b1;
            index_d  = idx_q;
            app_d    = 1'b0;
            op_d     = OP_NONE;
            len_d    = 3'd1;
            resp_d   = {32'hFFFF_FFFF, R1_ILLEGAL | r1_idle};
            cnt_d    = 8'd1;
            state_d  = ST_NCR;
            if ((idx_q == CMD0 && rx_byte != CRC_CMD0) ||
                (idx_q == CMD8 && rx_byte != CRC_CMD8)) begin
              resp_d[0] = R1_CRC_ERR | r1_idle;
            end else begin
              unique case (idx_q)
                CMD0: begin
                  resp_d[0] = R1_IDLE;
                  idle_d    = 1'b1;
                  polls_d   = 8'd0;
                end
                CMD8: begin
                  resp_d = {arg_q[7:0], 8'h01, 8'h00, 8'h00, r1_idle};
                  len_d  = 3'd5;
                end
                CMD55: begin
                  resp_d[0] = r1_idle;
                  app_d     = 1'b1;
                end
                CMD41: begin
                  if (app_q && polls_q < POLL_L) begin
                    resp_d[0] = R1_IDLE;
                    polls_d   = polls_q + 8'd1;
                  end else if (app_q) begin
                    resp_d[0] = 8'h00;
                    idle_d    = 1'b0;
                  end
                end
                CMD17, CMD24: begin
                  if (idle_q) begin
                    resp_d[0] = R1_ILLEGAL | R1_IDLE;
                  end else if (range_bad) begin
                    resp_d[0] = R1_PARAM_ERR;
                  end else begin
                    resp_d[0] = 8'h00;
                    op_d      = (idx_q == CMD17) ? OP_RD : OP_WR;
                    addr_d    = arg_q[AW-1:0];
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_NCR: begin
          if (cnt_q == NCR_L) begin
            tx_byte = resp_q[0];
            resp_d  = {8'hFF, resp_q[4:1]};
            cnt_d   = 8'd1;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (cnt_q < {5'd0, len_q}) begin
            tx_byte = resp_q[0];
            resp_d  = {8'hFF, resp_q[4:1]};
            cnt_d   = cnt_q + 8'd1;
          end else if (op_q == OP_RD) begin
            state_d = ST_RD_TOKEN;
          end else if (op_q == OP_WR) begin
            state_d = ST_WR_WAIT;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_RD_TOKEN: begin
          tx_byte = START_TOKEN;
          cnt_d   = 8'd0;
          state_d = ST_RD_DATA;
        end
        ST_RD_DATA: begin
          tx_byte = mem_q[mem_addr];
          if (cnt_q == BL_M1) begin
            cnt_d   = 8'd0;
            state_d = ST_RD_CRC;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RD_CRC: begin
          if (cnt_q == 8'd1) state_d = ST_HUNT;
          else               cnt_d = cnt_q + 8'd1;
        end
        ST_WR_WAIT: begin
          if (rx_byte == START_TOKEN) begin
            cnt_d   = 8'd0;
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          mem_we = 1'b1;
          if (cnt_q == BL_M1) begin
            cnt_d   = 8'd0;
            state_d = ST_WR_CRC;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WR_CRC: begin
          if (cnt_q == 8'd1) begin
            tx_byte = DATA_ACCEPTED;
            state_d = ST_WR_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WR_RESP: begin
          if (BUSY_L == 8'd0) begin
            state_d = ST_HUNT;
          end else begin
            tx_byte = 8'h00;
            cnt_d   = 8'd1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == BUSY_L) begin
            state_d = ST_HUNT;
          end else begin
            tx_byte = 8'h00;
            cnt_d   = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign cmd_strobe = strobe_q;
  assign cmd_index  = index_q;
  assign in_idle    = idle_q;

endmodule

// File: tb/tb_sd_spi_card_model.sv
// Directed bench for sd_spi_card_model: init sequence, block write/read, error codes, cs_n abort.
module tb_sd_spi_card_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic       cmd_strobe;
  logic [5:0] cmd_index;
  logic       in_idle;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;

  sd_spi_card_model dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .cmd_strobe(cmd_strobe),
    .cmd_index (cmd_index),
    .in_idle   (in_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #50;
      sclk  = 1'b1;
      rx[i] = miso;
      #50;
      sclk = 1'b0;
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    xfer(8'hFF, r);
    check(tag, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic wr(input logic [7:0] b);
    logic [7:0] r;
    xfer(b, r);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    wr({2'b01, idx});
    wr(arg[31:24]);
    wr(arg[23:16]);
    wr(arg[15:8]);
    wr(arg[7:0]);
    wr(crc);
  endtask

  task automatic r1_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] crc, input logic [7:0] exp_r1);
    int s0;
    s0 = strobe_cnt;
    send_cmd(idx, arg, crc);
    rd({tag, "_ncr"}, 8'hFF);
    rd({tag, "_r1"}, exp_r1);
    check({tag, "_strobe"}, strobe_cnt, s0 + 1);
    check({tag, "_index"}, {26'd0, cmd_index}, {26'd0, idx});
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b1;
    cs_n = 1'b1;
    #22;
    check("rst_miso", {31'd0, miso}, 32'd1);
    check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
    check("rst_index", {26'd0, cmd_index}, 32'd0);
    check("rst_idle", {31'd0, in_idle}, 32'd1);
    rst = 1'b0;
    #100;
    cs_n = 1'b0;
    #100;
    rd("hunt_ff0", 8'hFF);
    rd("hunt_ff1", 8'hFF);

    r1_cmd("cmd0", 6'd0, 32'h0, 8'h95, 8'h01);
    r1_cmd("cmd0_badcrc", 6'd0, 32'h0, 8'h00, 8'h09);
    check("badcrc_idle", {31'd0, in_idle}, 32'd1);

    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    rd("cmd8_ncr", 8'hFF);
    rd("cmd8_r1", 8'h01);
    rd("cmd8_b1", 8'h00);
    rd("cmd8_b2", 8'h00);
    rd("cmd8_b3", 8'h01);
    rd("cmd8_echo", 8'hAA);
    check("cmd8_index", {26'd0, cmd_index}, 32'd8);

    r1_cmd("cmd17_idle", 6'd17, 32'd0, 8'hFF, 8'h05);

    r1_cmd("cmd55_a", 6'd55, 32'd0, 8'hFF, 8'h01);
    r1_cmd("acmd41_a", 6'd41, 32'h4000_0000, 8'hFF, 8'h01);
    r1_cmd("cmd55_b", 6'd55, 32'd0, 8'hFF, 8'h01);
    r1_cmd("acmd41_b", 6'd41, 32'h4000_0000, 8'hFF, 8'h01);
    check("idle_after_2polls", {31'd0, in_idle}, 32'd1);
    r1_cmd("cmd55_c", 6'd55, 32'd0, 8'hFF, 8'h01);
    r1_cmd("acmd41_c", 6'd41, 32'h4000_0000, 8'hFF, 8'h00);
    check("idle_after_init", {31'd0, in_idle}, 32'd0);

    r1_cmd("cmd24", 6'd24, 32'd16, 8'hFF, 8'h00);
    rd("wr_gap", 8'hFF);
    wr(8'hFE);
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
    wr(8'hFF);
    wr(8'hFF);
    rd("wr_accept", 8'h05);
    rd("wr_busy0", 8'h00);
    rd("wr_busy1", 8'h00);
    rd("wr_done", 8'hFF);

    r1_cmd("cmd17_16", 6'd17, 32'd16, 8'hFF, 8'h00);
    rd("rd_gap", 8'hFF);
    rd("rd_token", 8'hFE);
    for (int i = 0; i < 16; i++) rd("rd16_data", 8'hA0 + 8'(i));
    rd("rd_crc0", 8'hFF);
    rd("rd_crc1", 8'hFF);

    r1_cmd("cmd17_32", 6'd17, 32'd32, 8'hFF, 8'h00);
    rd("rd32_gap", 8'hFF);
    rd("rd32_token", 8'hFE);
    for (int i = 0; i < 16; i++) rd("rd32_data", 8'h20 + 8'(i));
    rd("rd32_crc0", 8'hFF);
    rd("rd32_crc1", 8'hFF);

    r1_cmd("cmd17_56", 6'd17, 32'd56, 8'hFF, 8'h40);
    r1_cmd("cmd17_48", 6'd17, 32'd48, 8'hFF, 8'h00);
    rd("rd48_gap", 8'hFF);
    rd("rd48_token", 8'hFE);
    rd("rd48_d0", 8'h30);
    rd("rd48_d1", 8'h31);
    cs_n = 1'b1;
    #100;
    check("abort_miso", {31'd0, miso}, 32'd1);
    #100;
    cs_n = 1'b0;
    #100;
    r1_cmd("cmd0_after_abort", 6'd0, 32'h0, 8'h95, 8'h01);
    check("idle_after_cmd0", {31'd0, in_idle}, 32'd1);
    r1_cmd("cmd13_illegal", 6'd13, 32'h0, 8'hFF, 8'h05);
    cs_n = 1'b1;
    #100;
    check("end_miso", {31'd0, miso}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
